// File: rtl/pifo_sorted_block.sv
// Sorted PIFO rank queue: minimum-rank descriptor always at slot 0; equal ranks leave in arrival order.
// Latency: a pushed entry is visible at the head one cycle after the push handshake (no bypass).
// Backpressure: push refused only when full with no same-cycle pop; a refused push sets sticky overflow_err.
// Ports: clk_in_0 / reset (synchronous, active-low); s_push_* push side; m_pop_* head/pop side;
//        flush clears all entries; count / almost_full / full occupancy status; overflow_err sticky error.
module pifo_sorted_block #(
  parameter int RANK_WIDTH         = 16,
  parameter int META_WIDTH         = 32,
  parameter int DEPTH              = 16,
  parameter int ALMOST_FULL_THRESH = DEPTH - 2,
  parameter int CNT_WIDTH          = $clog2(DEPTH + 1)
) (
  input  logic                  clk_in_0,
  input  logic                  reset,
  input  logic                  s_push_valid,
  output logic                  s_push_ready,
  input  logic [RANK_WIDTH-1:0] s_push_rank,
  input  logic [META_WIDTH-1:0] s_push_meta,
  output logic                  m_pop_valid,
  input  logic                  m_pop_ready,
  output logic [RANK_WIDTH-1:0] m_pop_rank,
  output logic [META_WIDTH-1:0] m_pop_meta,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  almost_full,
  output logic                  full,
  output logic                  overflow_err
);

  logic                  r_vld  [DEPTH];
  logic [RANK_WIDTH-1:0] r_rank [DEPTH];
  logic [META_WIDTH-1:0] r_meta [DEPTH];
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_ovf;

  logic                  w_nx_vld  [DEPTH];
  logic [RANK_WIDTH-1:0] w_nx_rank [DEPTH];
  logic [META_WIDTH-1:0] w_nx_meta [DEPTH];

  // Neighbour views: slot i+1 (pop shift) and slot i-1 (push shift); beyond the ends read as empty.
  logic                  w_up_vld  [DEPTH];
  logic [RANK_WIDTH-1:0] w_up_rank [DEPTH];
  logic [META_WIDTH-1:0] w_up_meta [DEPTH];
  logic [RANK_WIDTH-1:0] w_dn_rank [DEPTH];
  logic [META_WIDTH-1:0] w_dn_meta [DEPTH];
  logic                  w_dn_vld  [DEPTH];

  // w_le[i]: slot i is valid and ranks at or below the new entry. Because valid slots are
  // contiguous and sorted, this is a thermometer and p is the index of its first zero.
  logic [DEPTH:0]   w_le;
  logic [DEPTH-1:0] w_prev_le;  // w_le[i-1], forced 1 for slot 0
  logic [DEPTH-1:0] w_le_or0;   // w_le[i], forced 1 for slot 0 (q = max(p-1,0))

  logic w_full, w_push_fire, w_pop_fire;

  genvar g;
  for (g = 0; g < DEPTH; g++) begin : g_slot
    assign w_le[g] = r_vld[g] & (r_rank[g] <= s_push_rank);
    if (g == DEPTH - 1) begin : g_top
      assign w_up_vld[g]  = 1'b0;
      assign w_up_rank[g] = '0;
      assign w_up_meta[g] = '0;
    end else begin : g_mid
      assign w_up_vld[g]  = r_vld[g+1];
      assign w_up_rank[g] = r_rank[g+1];
      assign w_up_meta[g] = r_meta[g+1];
    end
    if (g == 0) begin : g_bot
      assign w_dn_vld[g]  = 1'b0;
      assign w_dn_rank[g] = '0;
      assign w_dn_meta[g] = '0;
    end else begin : g_low
      assign w_dn_vld[g]  = r_vld[g-1];
      assign w_dn_rank[g] = r_rank[g-1];
      assign w_dn_meta[g] = r_meta[g-1];
    end
  end
  assign w_le[DEPTH] = 1'b0;
  assign w_prev_le   = {w_le[DEPTH-2:0], 1'b1};
  assign w_le_or0    = w_le[DEPTH-1:0] | DEPTH'(1);

  assign w_full       = (r_count == CNT_WIDTH'(DEPTH));
  assign s_push_ready = ~w_full | m_pop_ready;
  assign w_push_fire  = s_push_valid & s_push_ready;
  assign w_pop_fire   = r_vld[0] & m_pop_ready;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_nx_vld[i]  = r_vld[i];
      w_nx_rank[i] = r_rank[i];
      w_nx_meta[i] = r_meta[i];
      if (flush) begin
        w_nx_vld[i] = 1'b0;
      end else if (w_push_fire && w_pop_fire) begin
        // Slots below q shift toward the head, slot q takes the new entry, the rest hold.
        if (w_le[i+1]) begin
          w_nx_vld[i]  = w_up_vld[i];
          w_nx_rank[i] = w_up_rank[i];
          w_nx_meta[i] = w_up_meta[i];
        end else if (w_le_or0[i]) begin
          w_nx_vld[i]  = 1'b1;
          w_nx_rank[i] = s_push_rank;
          w_nx_meta[i] = s_push_meta;
        end
      end else if (w_push_fire) begin
        // Slots below p hold, slot p takes the new entry, the rest shift away from the head.
        if (!w_le[i]) begin
          if (w_prev_le[i]) begin
            w_nx_vld[i]  = 1'b1;
            w_nx_rank[i] = s_push_rank;
            w_nx_meta[i] = s_push_meta;
          end else begin
            w_nx_vld[i]  = w_dn_vld[i];
            w_nx_rank[i] = w_dn_rank[i];
            w_nx_meta[i] = w_dn_meta[i];
          end
        end
      end else if (w_pop_fire) begin
        w_nx_vld[i]  = w_up_vld[i];
        w_nx_rank[i] = w_up_rank[i];
        w_nx_meta[i] = w_up_meta[i];
      end
    end
  end

  always_ff @(posedge clk_in_0) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i]  <= 1'b0;
        r_rank[i] <= '0;
        r_meta[i] <= '0;
      end
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i]  <= w_nx_vld[i];
        r_rank[i] <= w_nx_rank[i];
        r_meta[i] <= w_nx_meta[i];
      end
      if (flush) begin
        r_count <= '0;
      end else if (w_push_fire && !w_pop_fire) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end else if (w_pop_fire && !w_push_fire) begin
        r_count <= r_count - CNT_WIDTH'(1);
      end
      // Survives flush; only reset clears it.
      if (s_push_valid && !s_push_ready) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign m_pop_valid  = r_vld[0];
  assign m_pop_rank   = r_rank[0];
  assign m_pop_meta   = r_meta[0];
  assign count        = r_count;
  assign full         = w_full;
  assign almost_full  = (r_count >= CNT_WIDTH'(ALMOST_FULL_THRESH));
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_pifo_sorted_block.sv
module tb_pifo_sorted_block;
  localparam int RW    = 16;
  localparam int MW    = 32;
  localparam int DEPTH = 16;
  localparam int AFT   = DEPTH - 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, push_v, pop_r, flush_i;
  logic [RW-1:0] push_rank;
  logic [MW-1:0] push_meta;
  logic          push_rdy, pop_v, af, fl, ovf;
  logic [RW-1:0] pop_rank;
  logic [MW-1:0] pop_meta;
  logic [CW-1:0] cnt;

  pifo_sorted_block #(
    .RANK_WIDTH(RW), .META_WIDTH(MW), .DEPTH(DEPTH),
    .ALMOST_FULL_THRESH(AFT), .CNT_WIDTH(CW)
  ) dut (
    .clk_in_0(clk), .reset(rst_n),
    .s_push_valid(push_v), .s_push_ready(push_rdy),
    .s_push_rank(push_rank), .s_push_meta(push_meta),
    .m_pop_valid(pop_v), .m_pop_ready(pop_r),
    .m_pop_rank(pop_rank), .m_pop_meta(pop_meta),
    .flush(flush_i), .count(cnt), .almost_full(af), .full(fl),
    .overflow_err(ovf)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input bit pv, input logic [RW-1:0] rk, input logic [MW-1:0] mt,
                       input bit pr, input bit fls);
    push_v = pv; push_rank = rk; push_meta = mt; pop_r = pr; flush_i = fls;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    bit          pv;
    logic [RW-1:0] rk;
    logic [MW-1:0] mt;
    bit          pr;
    bit          ev;
    logic [RW-1:0] er;
    logic [MW-1:0] em;
    int          ec;
  } vec_t;

  function automatic vec_t mk(bit pv, int rk, int mt, bit pr, bit ev, int er, int em, int ec);
    vec_t v;
    v.pv = pv; v.rk = RW'(rk); v.mt = MW'(mt); v.pr = pr;
    v.ev = ev; v.er = RW'(er); v.em = MW'(em); v.ec = ec;
    return v;
  endfunction

  vec_t tbl[17];

  // ---------------- reference model ----------------
  typedef struct {
    logic [RW-1:0] rank;
    logic [MW-1:0] meta;
    int            seq;
  } ent_t;

  ent_t mq[$];
  int   seq_ctr;
  bit   m_ovf;

  // Head = smallest rank, oldest arrival among equals.
  function automatic int head_idx();
    int h = 0;
    for (int k = 1; k < mq.size(); k++) begin
      if (mq[k].rank < mq[h].rank ||
          (mq[k].rank == mq[h].rank && mq[k].seq < mq[h].seq)) h = k;
    end
    return h;
  endfunction

  initial begin
    bit   exp_rdy, pf, qf, pv, pr, fls;
    int   h, phase;
    logic [RW-1:0] rk;
    logic [MW-1:0] mt;

    rst_n = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_valid", pop_v, 0);
    chk("rst_rank", pop_rank, 0);
    chk("rst_meta", pop_meta, 0);
    chk("rst_count", cnt, 0);
    chk("rst_full", fl, 0);
    chk("rst_af", af, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    // Ordering with ties, combined push+pop, and pop of an empty queue.
    tbl[0]  = mk(1, 5, 'hA, 0, 1, 5, 'hA, 1);
    tbl[1]  = mk(1, 3, 'hB, 0, 1, 3, 'hB, 2);
    tbl[2]  = mk(1, 9, 'hC, 0, 1, 3, 'hB, 3);
    tbl[3]  = mk(1, 3, 'hD, 0, 1, 3, 'hB, 4);
    tbl[4]  = mk(0, 0, 0,   1, 1, 3, 'hD, 3);
    tbl[5]  = mk(0, 0, 0,   1, 1, 5, 'hA, 2);
    tbl[6]  = mk(0, 0, 0,   1, 1, 9, 'hC, 1);
    tbl[7]  = mk(0, 0, 0,   1, 0, 0, 0,   0);
    tbl[8]  = mk(1, 4, 'h4, 0, 1, 4, 'h4, 1);
    tbl[9]  = mk(1, 8, 'h8, 0, 1, 4, 'h4, 2);
    tbl[10] = mk(1, 2, 'h2, 1, 1, 2, 'h2, 2);
    tbl[11] = mk(0, 0, 0,   1, 1, 8, 'h8, 1);
    tbl[12] = mk(0, 0, 0,   1, 0, 0, 0,   0);
    tbl[13] = mk(1, 4, 'h4, 0, 1, 4, 'h4, 1);
    tbl[14] = mk(1, 6, 'h6, 1, 1, 6, 'h6, 1);
    tbl[15] = mk(0, 0, 0,   1, 0, 0, 0,   0);
    tbl[16] = mk(0, 0, 0,   1, 0, 0, 0,   0);

    for (int v = 0; v < 17; v++) begin
      apply(tbl[v].pv, tbl[v].rk, tbl[v].mt, tbl[v].pr, 1'b0);
      tick();
      chk($sformatf("tbl%0d_valid", v), pop_v, tbl[v].ev);
      chk($sformatf("tbl%0d_count", v), cnt, tbl[v].ec);
      if (tbl[v].ev) begin
        chk($sformatf("tbl%0d_rank", v), pop_rank, tbl[v].er);
        chk($sformatf("tbl%0d_meta", v), pop_meta, tbl[v].em);
      end
    end
    idle();

    // Almost-full threshold.
    for (int k = 0; k < AFT; k++) begin
      apply(1'b1, RW'(100 + k), MW'(k), 1'b0, 1'b0);
      tick();
      chk($sformatf("af_after_push%0d", k + 1), af, (k + 1 >= AFT));
    end
    apply(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chk("af_after_pop", af, 0);
    chk("af_pop_count", cnt, AFT - 1);
    chk("af_pop_head", pop_rank, 101);
    apply(1'b1, RW'(100), MW'(0), 1'b0, 1'b0); tick();
    apply(1'b1, RW'(114), MW'(14), 1'b0, 1'b0); tick();
    apply(1'b1, RW'(115), MW'(15), 1'b0, 1'b0); tick();
    chk("fill_count", cnt, DEPTH);
    chk("fill_full", fl, 1);
    chk("fill_head", pop_rank, 100);

    // Push while full without pop is refused.
    apply(1'b1, RW'(7), MW'(77), 1'b0, 1'b0);
    #1;
    chk("full_push_rdy", push_rdy, 0);
    tick();
    chk("full_ovf", ovf, 1);
    chk("full_head", pop_rank, 100);
    chk("full_count", cnt, DEPTH);
    // Same push with a pop is accepted and lands at the head.
    apply(1'b1, RW'(7), MW'(77), 1'b1, 1'b0);
    #1;
    chk("full_pop_push_rdy", push_rdy, 1);
    tick();
    chk("full_swap_head", pop_rank, 7);
    chk("full_swap_meta", pop_meta, 77);
    chk("full_swap_count", cnt, DEPTH);
    apply(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chk("full_next_head", pop_rank, 101);
    chk("full_next_count", cnt, DEPTH - 1);

    // Flush, then flush with a concurrent push.
    apply(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    chk("flush_count", cnt, 0);
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, RW'(20 - k), MW'(k), 1'b0, 1'b0);
      tick();
    end
    chk("flush5_count", cnt, 5);
    chk("flush5_head", pop_rank, 16);
    apply(1'b1, RW'(1), MW'(1), 1'b0, 1'b1);
    tick();
    chk("flushp_count", cnt, 0);
    chk("flushp_valid", pop_v, 0);
    chk("flushp_ovf_kept", ovf, 1);

    // Reset mid-stream overrides a push.
    apply(1'b1, RW'(9), MW'(9), 1'b0, 1'b0); tick();
    apply(1'b1, RW'(3), MW'(3), 1'b0, 1'b0); tick();
    rst_n = 1'b0;
    apply(1'b1, RW'(2), MW'(2), 1'b1, 1'b0);
    tick();
    chk("mrst_valid", pop_v, 0);
    chk("mrst_rank", pop_rank, 0);
    chk("mrst_meta", pop_meta, 0);
    chk("mrst_count", cnt, 0);
    chk("mrst_ovf", ovf, 0);
    chk("mrst_af", af, 0);
    chk("mrst_full", fl, 0);
    rst_n = 1'b1;
    idle();
    tick();

    // Randomised traffic against the reference model.
    mq.delete();
    seq_ctr = 0;
    m_ovf   = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      phase = (c / 150) % 3;
      case (phase)
        0:       begin pv = ($urandom_range(0, 9) < 8); pr = ($urandom_range(0, 9) < 2); end
        1:       begin pv = ($urandom_range(0, 9) < 2); pr = ($urandom_range(0, 9) < 8); end
        default: begin pv = $urandom_range(0, 1);       pr = $urandom_range(0, 1);       end
      endcase
      fls = ($urandom_range(0, 199) == 0);
      rk  = RW'($urandom_range(0, 7));
      mt  = MW'($urandom);
      apply(pv, rk, mt, pr, fls);
      #1;
      exp_rdy = (mq.size() != DEPTH) || pr;
      chk("rnd_push_rdy", push_rdy, exp_rdy);
      pf = pv && exp_rdy;
      qf = pr && (mq.size() > 0);
      if (pv && !exp_rdy) m_ovf = 1'b1;
      if (fls) begin
        mq.delete();
      end else begin
        if (qf) mq.delete(head_idx());
        if (pf) begin
          mq.push_back('{rank: rk, meta: mt, seq: seq_ctr});
          seq_ctr++;
        end
      end
      tick();
      chk("rnd_valid", pop_v, (mq.size() > 0));
      if (mq.size() > 0) begin
        h = head_idx();
        chk("rnd_rank", pop_rank, mq[h].rank);
        chk("rnd_meta", pop_meta, mq[h].meta);
      end
      chk("rnd_count", cnt, mq.size());
      chk("rnd_full", fl, (mq.size() == DEPTH));
      chk("rnd_af", af, (mq.size() >= AFT));
      chk("rnd_ovf", ovf, m_ovf);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
